sdf_delay_feedback: RTL and testbench

Single-path delay-feedback (SDF) controller for one decimation-in-frequency stage of the sequential FFT. It sits directly upstream of the stage's radix-2 butterfly, which is combinational. The block buffers the first half of each block of 2·DELAY samples and pairs each buffered sample with its partner at distance DELAY. It drives the butterfly inputs and twiddle-ROM address, stores the butterfly's twiddled difference output, and serialises sums then differences into the next stage.

---
 rtl/sdf_delay_feedback_pkg.sv | 31 +++
 rtl/sdf_delay_feedback_delay_line.sv | 26 ++
 rtl/sdf_delay_feedback.sv | 118 +++++++++++
 tb/tb_sdf_delay_feedback.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdf_delay_feedback_pkg.sv
// Shared FFT stage definitions: sample-pair type, SDF phase encoding and a
// constant clog2 helper used by the butterfly and the stage controllers.
package sdf_delay_feedback_pkg;

  localparam int unsigned BIT_W = 16;
  localparam int unsigned TW_W  = 8;

  typedef struct packed {
    logic signed [BIT_W-1:0] re;
    logic signed [BIT_W-1:0] im;
  } sample_t;

  // Phase A fills the delay line, phase B pairs head with the current sample.
  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sdf_delay_feedback_delay_line.sv
// Enabled shift register of DEPTH words; head is the oldest stored word.
// Storage is intentionally not reset; consumers mask stale contents.
module sdf_delay_line #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        mem[i] <= mem[i+1];
      end
      mem[DEPTH-1] <= din;
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/sdf_delay_feedback.sv
// Single-path delay-feedback controller for one DIF FFT stage: buffers the
// first half block, feeds the external butterfly, serialises sums then diffs.
module sdf_delay_feedback
  import sdf_delay_feedback_pkg::*;
#(
  parameter int unsigned bit_width = BIT_W,
  parameter int unsigned DELAY     = 8,
  parameter int unsigned TW_STRIDE = 1,
  parameter int unsigned TW_AW     = TW_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic                        flush,
  input  logic signed [bit_width-1:0] Re_in,
  input  logic signed [bit_width-1:0] Im_in,
  output logic signed [bit_width-1:0] bf_Re_i1,
  output logic signed [bit_width-1:0] bf_Im_i1,
  output logic signed [bit_width-1:0] bf_Re_i2,
  output logic signed [bit_width-1:0] bf_Im_i2,
  input  logic signed [bit_width-1:0] bf_Re_o1,
  input  logic signed [bit_width-1:0] bf_Im_o1,
  input  logic signed [bit_width-1:0] bf_Re_o2,
  input  logic signed [bit_width-1:0] bf_Im_o2,
  output logic        [TW_AW-1:0]     tw_addr,
  output logic                        out_valid,
  output logic signed [bit_width-1:0] Re_out,
  output logic signed [bit_width-1:0] Im_out
);

  localparam int unsigned CNT_W = clog2(2 * DELAY);
  localparam int unsigned IDX_W = clog2(DELAY);
  localparam int unsigned SMP_W = 2 * bit_width;

  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_next;
  logic                        primed;
  logic                        primed_next;
  logic                        adv;
  phase_e                      phase;
  logic signed [bit_width-1:0] smp_re;
  logic signed [bit_width-1:0] smp_im;
  logic signed [bit_width-1:0] head_re;
  logic signed [bit_width-1:0] head_im;
  logic signed [bit_width-1:0] mux_re;
  logic signed [bit_width-1:0] mux_im;
  logic [SMP_W-1:0]            dl_din;
  logic [SMP_W-1:0]            dl_head;
  logic [31:0]                 tw_prod;

  // Flush advances the pipeline with a zero sample; a real sample wins.
  always_comb begin : next_state
    adv         = in_valid | flush;
    phase       = phase_e'(cnt[CNT_W-1]);
    smp_re      = in_valid ? Re_in : '0;
    smp_im      = in_valid ? Im_in : '0;
    cnt_next    = cnt;
    primed_next = primed;
    if (adv) begin
      cnt_next = CNT_W'(cnt + 1'b1);
      if (phase == PH_B) begin
        primed_next = 1'b1;
      end
    end
  end

  always_comb begin : datapath
    head_re  = dl_head[SMP_W-1 -: bit_width];
    head_im  = dl_head[bit_width-1:0];
    bf_Re_i1 = head_re;
    bf_Im_i1 = head_im;
    bf_Re_i2 = smp_re;
    bf_Im_i2 = smp_im;
    tw_prod  = 32'(cnt[IDX_W-1:0]) * 32'(TW_STRIDE);
    dl_din   = {smp_re, smp_im};
    mux_re   = head_re;
    mux_im   = head_im;
    tw_addr  = '0;
    // Phase B recirculates the twiddled difference and emits the sum.
    if (phase == PH_B) begin
      dl_din  = {bf_Re_o2, bf_Im_o2};
      mux_re  = bf_Re_o1;
      mux_im  = bf_Im_o1;
      tw_addr = TW_AW'(tw_prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      cnt       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      Re_out    <= '0;
      Im_out    <= '0;
    end else begin
      cnt    <= cnt_next;
      primed <= primed_next;
      if (adv) begin
        Re_out    <= mux_re;
        Im_out    <= mux_im;
        out_valid <= primed_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  sdf_delay_line #(
    .DEPTH (DELAY),
    .WIDTH (SMP_W)
  ) u_delay_line (
    .clk  (clk),
    .en   (adv),
    .din  (dl_din),
    .head (dl_head)
  );

endmodule

// File: tb/tb_sdf_delay_feedback.sv
// Self-checking bench for sdf_delay_feedback with a unity-twiddle butterfly.
module tb_sdf_delay_feedback;

  localparam int unsigned W      = 16;
  localparam int unsigned D      = 4;
  localparam int unsigned STRIDE = 2;
  localparam int unsigned AW     = 8;
  localparam int          TW_COS = 64;
  localparam int          TW_SIN = 0;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                flush = 1'b0;
  logic signed [W-1:0] Re_in = '0;
  logic signed [W-1:0] Im_in = '0;
  logic signed [W-1:0] bf_Re_i1, bf_Im_i1, bf_Re_i2, bf_Im_i2;
  logic signed [W-1:0] bf_Re_o1, bf_Im_o1, bf_Re_o2, bf_Im_o2;
  logic [AW-1:0]       tw_addr;
  logic                out_valid;
  logic signed [W-1:0] Re_out, Im_out;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  sdf_delay_feedback #(
    .bit_width (W),
    .DELAY     (D),
    .TW_STRIDE (STRIDE),
    .TW_AW     (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .flush     (flush),
    .Re_in     (Re_in),
    .Im_in     (Im_in),
    .bf_Re_i1  (bf_Re_i1),
    .bf_Im_i1  (bf_Im_i1),
    .bf_Re_i2  (bf_Re_i2),
    .bf_Im_i2  (bf_Im_i2),
    .bf_Re_o1  (bf_Re_o1),
    .bf_Im_o1  (bf_Im_o1),
    .bf_Re_o2  (bf_Re_o2),
    .bf_Im_o2  (bf_Im_o2),
    .tw_addr   (tw_addr),
    .out_valid (out_valid),
    .Re_out    (Re_out),
    .Im_out    (Im_out)
  );

  // Combinational butterfly: sum, and difference times twiddle (Q6, 1.0).
  int d_re, d_im, p_re, p_im;
  always_comb begin
    d_re     = int'(bf_Re_i1) - int'(bf_Re_i2);
    d_im     = int'(bf_Im_i1) - int'(bf_Im_i2);
    p_re     = d_re * TW_COS - d_im * TW_SIN;
    p_im     = d_im * TW_COS + d_re * TW_SIN;
    bf_Re_o1 = W'(int'(bf_Re_i1) + int'(bf_Re_i2));
    bf_Im_o1 = W'(int'(bf_Im_i1) + int'(bf_Im_i2));
    bf_Re_o2 = W'(p_re >>> 6);
    bf_Im_o2 = W'(p_im >>> 6);
  end

  // Block-level reference: sample k of a 2D block; first half is stored,
  // second half emits x[j]+x[j+D]; differences come out in the next first half.
  logic signed [W-1:0] cur_re [D];
  logic signed [W-1:0] cur_im [D];
  logic signed [W-1:0] pend_re [D];
  logic signed [W-1:0] pend_im [D];
  int                  mcnt;
  logic                mprimed;
  logic                exp_valid;
  logic signed [W-1:0] exp_re, exp_im;
  logic signed [W-1:0] s_re, s_im;
  logic [AW-1:0]       exp_tw;

  assign s_re   = in_valid ? Re_in : '0;
  assign s_im   = in_valid ? Im_in : '0;
  assign exp_tw = (mcnt >= int'(D)) ? AW'((mcnt - int'(D)) * int'(STRIDE)) : '0;

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      mcnt      <= 0;
      mprimed   <= 1'b0;
      exp_valid <= 1'b0;
      exp_re    <= '0;
      exp_im    <= '0;
    end else if (in_valid || flush) begin
      if (mcnt < int'(D)) begin
        cur_re[mcnt] <= s_re;
        cur_im[mcnt] <= s_im;
        exp_re       <= pend_re[mcnt];
        exp_im       <= pend_im[mcnt];
        exp_valid    <= mprimed;
      end else begin
        exp_re                <= W'(cur_re[mcnt-D] + s_re);
        exp_im                <= W'(cur_im[mcnt-D] + s_im);
        pend_re[mcnt-D]       <= W'(cur_re[mcnt-D] - s_re);
        pend_im[mcnt-D]       <= W'(cur_im[mcnt-D] - s_im);
        exp_valid             <= 1'b1;
        mprimed               <= 1'b1;
      end
      mcnt <= (mcnt + 1) % int'(2 * D);
    end else begin
      exp_valid <= 1'b0;
    end
  end

  logic signed [W-1:0] got_re [$];
  logic signed [W-1:0] got_im [$];
  logic signed [W-1:0] want_re [$];
  logic signed [W-1:0] want_im [$];

  // Per-cycle compare against the model, sampled away from the active edge.
  always @(negedge clk) begin : compare
    if (!rst_n) begin
      checks++;
      if (out_valid !== 1'b0 || Re_out !== '0 || Im_out !== '0) begin
        errors++;
        $display("FAIL reset_outputs: valid=%0b re=%0d im=%0d, required 0 0 0",
                 out_valid, Re_out, Im_out);
      end
    end else if (chk_en) begin
      checks++;
      if (out_valid !== exp_valid) begin
        errors++;
        $display("FAIL out_valid @%0t: got %0b, required %0b", $time, out_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (Re_out !== exp_re || Im_out !== exp_im) begin
          errors++;
          $display("FAIL out_data @%0t: got %0d/%0d, required %0d/%0d",
                   $time, Re_out, Im_out, exp_re, exp_im);
        end
      end
      checks++;
      if (tw_addr !== exp_tw) begin
        errors++;
        $display("FAIL tw_addr @%0t: got %0d, required %0d", $time, tw_addr, exp_tw);
      end
      if (out_valid === 1'b1) begin
        got_re.push_back(Re_out);
        got_im.push_back(Im_out);
      end
    end
  end

  task automatic step(input logic v, input logic f, input logic signed [W-1:0] re,
                      input logic signed [W-1:0] im);
    in_valid = v;
    flush    = f;
    Re_in    = re;
    Im_in    = im;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic gap_maybe(input bit gaps);
    while (gaps && $urandom_range(1, 0) == 1) begin
      step(1'b0, 1'b0, W'($urandom), W'($urandom));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    got_re.delete();
    got_im.delete();
    want_re.delete();
    want_im.delete();
  endtask

  task automatic want(input int re, input int im);
    want_re.push_back(W'(re));
    want_im.push_back(W'(im));
  endtask

  // Feed one block base..base+7 with Im = im_sign*Re, optional random gaps.
  task automatic feed_block(input int base, input int im_sign, input bit gaps);
    for (int i = 0; i < int'(2 * D); i++) begin
      gap_maybe(gaps);
      step(1'b1, 1'b0, W'(base + i), W'(im_sign * (base + i)));
    end
  endtask

  task automatic drain(input bit gaps);
    for (int i = 0; i < int'(D); i++) begin
      gap_maybe(gaps);
      step(1'b0, 1'b1, W'($urandom), W'($urandom));
    end
    repeat (3) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_stream(input string name);
    int n;
    checks++;
    if (got_re.size() != want_re.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs, required %0d", name, got_re.size(), want_re.size());
    end
    n = (got_re.size() < want_re.size()) ? got_re.size() : want_re.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_re[i] !== want_re[i] || got_im[i] !== want_im[i]) begin
        errors++;
        $display("FAIL %s[%0d]: got %0d/%0d, required %0d/%0d",
                 name, i, got_re[i], got_im[i], want_re[i], want_im[i]);
      end
    end
    got_re.delete();
    got_im.delete();
    want_re.delete();
    want_im.delete();
  endtask

  task automatic want_single_block();
    want(4, 0); want(6, 0); want(8, 0); want(10, 0);
    for (int i = 0; i < 4; i++) want(-4, 0);
  endtask

  initial begin
    #1;
    // Single block, continuous
    do_reset();
    feed_block(0, 0, 1'b0);
    drain(1'b0);
    want_single_block();
    check_stream("single");

    // Two back-to-back blocks
    do_reset();
    feed_block(0, 0, 1'b0);
    feed_block(10, 0, 1'b0);
    drain(1'b0);
    want(4, 0); want(6, 0); want(8, 0); want(10, 0);
    for (int i = 0; i < 4; i++) want(-4, 0);
    want(24, 0); want(26, 0); want(28, 0); want(30, 0);
    for (int i = 0; i < 4; i++) want(-4, 0);
    check_stream("two_blocks");

    // Random stalls must not change the sequence
    do_reset();
    feed_block(0, 0, 1'b1);
    drain(1'b1);
    want_single_block();
    check_stream("gaps");

    // Reset mid-block discards the partial block
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, W'(100 + i), W'(-7));
    do_reset();
    feed_block(0, 0, 1'b0);
    drain(1'b0);
    want_single_block();
    check_stream("mid_reset");

    // Complex input Im = -Re
    do_reset();
    feed_block(0, -1, 1'b0);
    drain(1'b0);
    want(4, -4); want(6, -6); want(8, -8); want(10, -10);
    for (int i = 0; i < 4; i++) want(-4, 4);
    check_stream("complex");

    // Randomised traffic, checked cycle by cycle against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) == 0),
           W'($urandom), W'($urandom));
    end
    drain(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
